serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Bit-serial multi-bit subtractor controller that computes A − B − bin_in.
- Time-shares a single 1-bit full-subtractor cell over WIDTH cycles, LSB first.
- Captures operands with a start/ready handshake, iterates the cell while carrying the borrow in a register, then presents a held result with a one-cycle done pulse.
- Sits between a requesting master and the 1-bit subtractor datapath; serves as the area-minimal alternative to a ripple subtractor.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- a_in  input  WIDTH  minuend, sampled on the accepting edge
- b_in  input  WIDTH  subtrahend, sampled on the accepting edge
- bin_in  input  1  initial borrow-in, sampled on the accepting edge
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN only
- done  output  1  one-cycle pulse, high in DONE only
- diff_out  output  WIDTH  result, held from DONE until the next completion
- borrow_out  output  1  final borrow, held like diff_out

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, ready=1, busy=0, done=0.
  - diff_out=0, borrow_out=0; internal shift registers, borrow register and bit counter cleared.
- Per-bit cell equations: d = a^b^br; bnext = (~a&b) | (~(a^b)&br).
- State machine (3 states):
  - IDLE: on start=1 at edge E0:
    - load a_sh←a_in, b_sh←b_in, br←bin_in, cnt←0; go to RUN.
    - Otherwise stay in IDLE.
  - RUN: each edge processes bit cnt:
    - Shift a_sh and b_sh right; shift d into the MSB of the result shift register.
    - br←bnext; cnt←cnt+1.
    - On the edge that processes bit WIDTH−1 (edge E_WIDTH): diff_out←completed result, borrow_out←bnext; go to DONE.
  - DONE: done=1 for exactly one cycle; next edge returns unconditionally to IDLE.
- Latency:
  - done is high in the cycle following edge E_WIDTH, i.e. WIDTH clock cycles after the accepting edge.
  - Request-to-request throughput is WIDTH+2 cycles.
- Handshake:
  - start is ignored in RUN and DONE; there is no queueing.
  - Operands are not required to be stable after the accepting edge.
  - start held high continuously restarts on each IDLE cycle.
- Result registers:
  - diff_out and borrow_out change only at the completing edge (and on reset).
  - They are stable and held throughout IDLE/RUN of a subsequent operation until that operation completes.
- Arithmetic:
  - Result is (a_in − b_in − bin_in) mod 2^WIDTH.
  - borrow_out=1 iff a_in < b_in + bin_in as unsigned values.
- WIDTH=1: RUN lasts one cycle. Counter width is max(1, clog2(WIDTH)); the terminal compare is cnt==WIDTH−1.
- Reset mid-operation: RUN or DONE aborts immediately, no done pulse is produced, and outputs return to reset values.

Optional Feature:
- Macro: SERIAL_SUB_ZERO_FLAG_EN
- With the macro defined:
  - Extra output port zero_out (output, 1 bit, reset 0).
  - zero_out is updated at the completing edge to 1 iff the completed diff is all zeros; held like diff_out.
  - Computed incrementally during RUN (sticky-OR of d bits), not by a WIDTH-wide reduction.
- Without the macro: port and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, single start pulse -> done exactly 8 cycles after the accepting edge; diff_out=0x1E, borrow_out=0; ready returns 1 the cycle after done.
- WIDTH=8, a=0x00, b=0x01, bin=0 -> diff_out=0xFF, borrow_out=1; with the macro, zero_out=0.
- WIDTH=8, a=0x10, b=0x0F, bin=1 -> diff_out=0x00, borrow_out=0; with the macro, zero_out=1.
- Start 0x5A−0x3C, then pulse start with a=0xFF, b=0x00 on RUN cycle 3 -> second request ignored; result 0x1E; exactly one done pulse; diff_out retains the prior value until the completing edge.
- Start an operation, assert rst_n=0 asynchronously mid-RUN (between clock edges) -> busy=0, ready=1, diff_out=0, borrow_out=0 immediately; no done pulse; a new request after release yields the correct result.
- WIDTH=1, exhaustive a, b, bin (8 cases) -> done 1 cycle after accept; each {borrow_out, diff_out} matches the full-subtractor truth table (e.g. a=0, b=1, bin=1 -> diff=0, borrow=1).

Source files
------------

// File: rtl/serial_sub_if.sv
// Request/result bundle for the bit-serial subtractor controller.
// SERIAL_SUB_ZERO_FLAG_EN adds the zero_out result flag.
interface serial_sub_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             bin_in;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff_out;
   logic             borrow_out;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
   logic             zero_out;
`endif

   modport master (
      output start, a_in, b_in, bin_in,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      input  zero_out,
`endif
      input  ready, busy, done, diff_out, borrow_out
   );

   modport slave (
      input  start, a_in, b_in, bin_in,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      output zero_out,
`endif
      output ready, busy, done, diff_out, borrow_out
   );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - bin subtractor: one full-subtractor cell reused LSB first.
// Optional SERIAL_SUB_ZERO_FLAG_EN adds a registered zero_out result flag.
module serial_sub_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   serial_sub_if.slave bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] diff_q;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             borrow_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
   logic             nz;
   logic             zero_q;
`endif

   // Full-subtractor cell on the current LSBs, and the result with d shifted in.
   logic             d_c;
   logic             bnext_c;
   logic [WIDTH-1:0] r_next_c;

   assign d_c      = a_sh[0] ^ b_sh[0] ^ br;
   assign bnext_c  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
   assign r_next_c = (r_sh >> 1) | (WIDTH'(d_c) << (WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         r_sh     <= '0;
         diff_q   <= '0;
         cnt      <= '0;
         br       <= 1'b0;
         borrow_q <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
         nz       <= 1'b0;
         zero_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh    <= bus.a_in;
                  b_sh    <= bus.b_in;
                  br      <= bus.bin_in;
                  r_sh    <= '0;
                  cnt     <= '0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                  nz      <= 1'b0;
`endif
                  state   <= RUN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               r_sh <= r_next_c;
               br   <= bnext_c;
               cnt  <= cnt + CW'(1);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
               nz   <= nz | d_c;
`endif
               // Last bit: publish the result and the final borrow.
               if (cnt == CW'(WIDTH - 1)) begin
                  diff_q   <= r_next_c;
                  borrow_q <= bnext_c;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                  zero_q   <= ~(nz | d_c);
`endif
                  state    <= DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
            DONE: begin
               state   <= IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready      = ready_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.diff_out   = diff_q;
   assign bus.borrow_out = borrow_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
   assign bus.zero_out   = zero_q;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8 and WIDTH=1 instances).
// Zero-flag checks are compiled in when SERIAL_SUB_ZERO_FLAG_EN is defined.
module tb_serial_sub_ctrl;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   serial_sub_if #(.WIDTH(8)) bus8 ();
   serial_sub_if #(.WIDTH(1)) bus1 ();

   serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   serial_sub_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
      logic       z;
   } vec8_t;

   typedef struct {
      logic a;
      logic b;
      logic bin;
      logic d;
      logic bo;
   } vec1_t;

   int checks = 0;
   int errors = 0;

   logic [7:0] last_d8;
   logic       last_b8;
   logic       last_d1;
   logic       last_b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One WIDTH=8 operation: accept, watch latency, check result and return to idle.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] ed, input logic eb, input logic ez, input string tag);
      int n;
      bit seen;
      bus8.a_in = a; bus8.b_in = b; bus8.bin_in = bin; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.bin_in = 1'($urandom);
      chk({tag, " busy"}, 32'(bus8.busy), 32'd1);
      chk({tag, " held_diff"}, 32'(bus8.diff_out), 32'(last_d8));
      n = 0; seen = 1'b0;
      while (n < 20 && !seen) begin
         @(posedge clk); #1;
         n++;
         seen = bus8.done;
      end
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      chk({tag, " latency"}, 32'(n), 32'd8);
      chk({tag, " diff"}, 32'(bus8.diff_out), 32'(ed));
      chk({tag, " borrow"}, 32'(bus8.borrow_out), 32'(eb));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      chk({tag, " zero"}, 32'(bus8.zero_out), 32'(ez));
`endif
      @(posedge clk); #1;
      chk({tag, " ready_after"}, 32'({bus8.ready, bus8.done}), 32'b10);
      last_d8 = ed; last_b8 = eb;
      if (ez && 0) $display("unused");
   endtask

   task automatic op1(input vec1_t v, input int idx);
      int n;
      bit seen;
      string tag;
      tag = $sformatf("w1[%0d]", idx);
      bus1.a_in = v.a; bus1.b_in = v.b; bus1.bin_in = v.bin; bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      n = 0; seen = 1'b0;
      while (n < 10 && !seen) begin
         @(posedge clk); #1;
         n++;
         seen = bus1.done;
      end
      chk({tag, " latency"}, 32'(n), 32'd1);
      chk({tag, " result"}, 32'({bus1.borrow_out, bus1.diff_out}), 32'({v.bo, v.d}));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      chk({tag, " zero"}, 32'(bus1.zero_out), 32'(~v.d));
`endif
      @(posedge clk); #1;
      chk({tag, " ready_after"}, 32'(bus1.ready), 32'd1);
      last_d1 = v.d; last_b1 = v.bo;
   endtask

   initial begin
      vec8_t tbl8[3];
      vec1_t tbl1[8];
      int dones;

      tbl8[0] = '{a: 8'h5A, b: 8'h3C, bin: 1'b0, d: 8'h1E, bo: 1'b0, z: 1'b0};
      tbl8[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1, z: 1'b0};
      tbl8[2] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, bo: 1'b0, z: 1'b1};

      tbl1[0] = '{a: 0, b: 0, bin: 0, d: 0, bo: 0};
      tbl1[1] = '{a: 0, b: 0, bin: 1, d: 1, bo: 1};
      tbl1[2] = '{a: 0, b: 1, bin: 0, d: 1, bo: 1};
      tbl1[3] = '{a: 0, b: 1, bin: 1, d: 0, bo: 1};
      tbl1[4] = '{a: 1, b: 0, bin: 0, d: 1, bo: 0};
      tbl1[5] = '{a: 1, b: 0, bin: 1, d: 0, bo: 0};
      tbl1[6] = '{a: 1, b: 1, bin: 0, d: 0, bo: 0};
      tbl1[7] = '{a: 1, b: 1, bin: 1, d: 1, bo: 1};

      bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.bin_in = 1'b0;
      bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.bin_in = 1'b0;
      last_d8 = '0; last_b8 = 1'b0; last_d1 = 1'b0; last_b1 = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      chk("reset ctl", 32'({bus8.ready, bus8.busy, bus8.done}), 32'b100);
      chk("reset diff", 32'(bus8.diff_out), 32'd0);
      chk("reset borrow", 32'(bus8.borrow_out), 32'd0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      chk("reset zero", 32'(bus8.zero_out), 32'd0);
`endif

      for (int i = 0; i < 3; i++)
         op8(tbl8[i].a, tbl8[i].b, tbl8[i].bin, tbl8[i].d, tbl8[i].bo, tbl8[i].z,
             $sformatf("vec[%0d]", i));

      // Random operations against an arithmetic reference.
      for (int i = 0; i < 40; i++) begin
         logic [7:0] a, b, ed;
         logic bin, eb;
         int dm;
         a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
         if (i % 8 == 0) b = a;
         dm = int'(a) - int'(b) - int'(bin);
         ed = 8'(dm);
         eb = (int'(a) < int'(b) + int'(bin));
         op8(a, b, bin, ed, eb, (ed == 8'h00), $sformatf("rnd[%0d]", i));
      end

      // A start pulse during RUN is ignored; the prior result stays held.
      op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "pre_ign");
      bus8.a_in = 8'h5A; bus8.b_in = 8'h3C; bus8.bin_in = 1'b0; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      dones = 0;
      for (int n = 1; n <= 14; n++) begin
         @(posedge clk); #1;
         if (n == 3) begin bus8.start = 1'b1; bus8.a_in = 8'hFF; bus8.b_in = 8'h00; end
         if (n == 4) bus8.start = 1'b0;
         if (n == 7) chk("ign held", 32'(bus8.diff_out), 32'hFF);
         if (bus8.done) dones++;
      end
      chk("ign done_count", 32'(dones), 32'd1);
      chk("ign diff", 32'(bus8.diff_out), 32'h1E);
      chk("ign borrow", 32'(bus8.borrow_out), 32'd0);
      last_d8 = 8'h1E; last_b8 = 1'b0;

      // Asynchronous reset in the middle of RUN.
      bus8.a_in = 8'h00; bus8.b_in = 8'h01; bus8.bin_in = 1'b0; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst ctl", 32'({bus8.ready, bus8.busy, bus8.done}), 32'b100);
      chk("arst result", 32'({bus8.borrow_out, bus8.diff_out}), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      dones = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #1;
         if (bus8.done) dones++;
      end
      chk("arst no_done", 32'(dones), 32'd0);
      last_d8 = '0; last_b8 = 1'b0; last_d1 = 1'b0; last_b1 = 1'b0;
      op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, "post_rst");

      for (int i = 0; i < 8; i++) op1(tbl1[i], i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
